huff_pair_sink: RTL
===================

// Module: huff_pair_sink
// PURPOSE
//  Downstream of the per-table Huffman pair decoders (HT_xx) in the MP3 big_values path.
//  - Accepts one decoded (x,y) pair per valid cycle.
//  - Writes each pair into the granule sample memory (one 2x16-bit word per pair).
//  - Tracks the pair count and drives active_table, so the bit feeder routes the next bits to the correct HT_xx.
//  - After big_values pairs, zero-fills the remaining pair slots, then pulses granule_done.
// PARAMETERS
//  GRANULE_PAIRS  288  pair slots per granule (576 samples / 2)
//  SAMPLE_W       16   width of one signed sample
//  ADDR_W         9    pair-address width, ceil(log2(GRANULE_PAIRS))
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous, active-high reset
//  start          in   1          pulse: latch side info, begin granule
//  big_values     in   9          number of big_values pairs (0..288)
//  region1_start  in   10         first sample index of region1
//  region2_start  in   10         first sample index of region2
//  table_sel0     in   5          Huffman table for region0
//  table_sel1     in   5          Huffman table for region1
//  table_sel2     in   5          Huffman table for region2
//  pair_valid     in   1          decoder axiov: x_val/y_val valid this cycle
//  x_val          in   SAMPLE_W   signed decoded x
//  y_val          in   SAMPLE_W   signed decoded y
//  bits_enable    out  1          high while bits should be fed to the decoders
//  active_table   out  5          table the feeder must route bits to
//  wr_en          out  1          sample-memory write strobe
//  wr_addr        out  ADDR_W     pair address
//  wr_data        out  2*SAMPLE_W {x,y}; x in [31:16], y in [15:0]
//  granule_done   out  1          one-cycle pulse when all slots are written
//  err_overrun    out  1          sticky: pair_valid arrived outside the BIGV state
// BEHAVIOUR
//  - Reset: state=IDLE; pair_cnt=0; all outputs 0; err_overrun=0.
//  - Latched on start: big_values, region1_start, region2_start, table_sel0..2.
//  - FSM IDLE -> BIGV: on start when big_values>0.
//  - FSM IDLE -> ZFILL: on start when big_values==0.
//  - FSM BIGV -> ZFILL: on the cycle that accepts pair number big_values-1.
//  - FSM ZFILL -> DONE: after writing address GRANULE_PAIRS-1.
//  - FSM DONE -> IDLE: next cycle; granule_done=1 for exactly the DONE cycle.
//  - start in any state restarts: pair_cnt=0, new side info latched, err_overrun cleared.
//    This includes start mid-BIGV or mid-ZFILL; no partial write is issued on that cycle.
//  - BIGV:
//    - bits_enable=1.
//    - Each pair_valid: wr_en=1 the SAME cycle (zero latency, combinational).
//    - wr_addr=pair_cnt, wr_data={x_val,y_val}; pair_cnt++ at the clock edge.
//    - Accepts pair_valid on back-to-back cycles, since 1-bit codes are legal.
//  - active_table: combinational from pair_cnt, sample index s = 2*pair_cnt (10-bit compare).
//    - s < region1_start                  -> table_sel0
//    - region1_start <= s < region2_start -> table_sel1
//    - otherwise                          -> table_sel2
//    - The value updates the cycle after a pair is accepted, in time for the next code's first bit.
//  - ZFILL:
//    - bits_enable=0; wr_en=1 every cycle; wr_addr=pair_cnt; wr_data=0.
//    - pair_cnt runs from big_values through GRANULE_PAIRS-1.
//    - The count1 region is written later, by a separate block, over these zeros.
//  - IDLE and DONE: wr_en=0, bits_enable=0, active_table holds its last value.
//  - Overrun: pair_valid in IDLE, ZFILL or DONE sets err_overrun and is otherwise ignored (no write).
//  - Out-of-range side info:
//    - big_values > GRANULE_PAIRS is clamped to GRANULE_PAIRS.
//    - region2_start < region1_start: region1 is empty, so the table_sel0 -> table_sel2 decision uses region1_start only.
//  - pair_cnt never exceeds GRANULE_PAIRS-1; there is no wrap-around within a granule.
// STRUCTURE
//  - mp3_pkg: GRANULE_PAIRS, SAMPLE_W, typedef enum {IDLE,BIGV,ZFILL,DONE} pair_sink_state_t, typedef table_sel_t [4:0].
//  - One sub-module, huff_region_sel: pure combinational mapping of (pair_cnt, boundaries, sels) -> active_table.
//  - Sample memory lives outside this block.
// TESTING
//  1. big_values=3, r1=2, r2=4, sels 1/5/24; pairs (1,-2),(15,0),(-3,3) back-to-back
//     -> writes addr 0..2 with {0001,FFFE},{000F,0000},{FFFD,0003};
//     -> active_table 1,5,24 in turn; then ZFILL writes 3..287 =0; granule_done at DONE.
//  2. big_values=0 -> no BIGV, bits_enable stays 0;
//     -> 288 zero writes on consecutive cycles, then one granule_done pulse.
//  3. Spaced pairs (pair_valid every 4th cycle), big_values=5 -> exactly 5 writes;
//     -> no write on idle cycles; pair_cnt=5 on entry to ZFILL.
//  4. Extra pair_valid during ZFILL -> err_overrun=1, no corrupted write;
//     -> next start clears err_overrun.
//  5. start at pair 2 of 10 -> pair_cnt=0, new tables apply, next pair written at addr 0.
//  6. rst asserted mid-ZFILL -> next cycle: IDLE, wr_en=0, granule_done=0, all outputs 0.

Source files
------------

// File: rtl/mp3_pkg.sv
// Shared constants and types for the MP3 big_values pair path.
package mp3_pkg;

  localparam int unsigned GRANULE_PAIRS = 288;
  localparam int unsigned SAMPLE_W      = 16;
  localparam int unsigned ADDR_W        = 9;
  localparam int unsigned REGION_W      = 10;

  typedef enum logic [1:0] {
    IDLE,
    BIGV,
    ZFILL,
    DONE
  } pair_sink_state_t;

  typedef logic [4:0] table_sel_t;

  // Side info may claim more pairs than a granule holds; cap at the slot count.
  function automatic logic [ADDR_W-1:0] clamp_big_values(input logic [ADDR_W-1:0] bv);
    if (bv > ADDR_W'(GRANULE_PAIRS)) return ADDR_W'(GRANULE_PAIRS);
    return bv;
  endfunction

endpackage

// File: rtl/huff_region_sel.sv
// Maps the current pair index to the Huffman table of the region it falls in.
module huff_region_sel
  import mp3_pkg::*;
(
  input  logic [ADDR_W-1:0]   i_pair_cnt,
  input  logic [REGION_W-1:0] i_region1_start,
  input  logic [REGION_W-1:0] i_region2_start,
  input  table_sel_t          i_table_sel0,
  input  table_sel_t          i_table_sel1,
  input  table_sel_t          i_table_sel2,
  output table_sel_t          o_active_table
);

  logic [REGION_W-1:0] w_sample_idx;

  assign w_sample_idx = {i_pair_cnt, 1'b0};

  // An inverted boundary pair means region1 is empty: only region1_start splits 0 from 2.
  always_comb begin
    o_active_table = i_table_sel2;
    if (w_sample_idx < i_region1_start)
      o_active_table = i_table_sel0;
    else if ((i_region2_start >= i_region1_start) && (w_sample_idx < i_region2_start))
      o_active_table = i_table_sel1;
  end

endmodule

// File: rtl/huff_pair_sink.sv
// Collects decoded big_values pairs into granule memory, zero-fills the rest,
// and steers the bit feeder to the Huffman table of the current region.
module huff_pair_sink
  import mp3_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     big_values,
  input  logic [REGION_W-1:0]   region1_start,
  input  logic [REGION_W-1:0]   region2_start,
  input  logic [4:0]            table_sel0,
  input  logic [4:0]            table_sel1,
  input  logic [4:0]            table_sel2,
  input  logic                  pair_valid,
  input  logic [SAMPLE_W-1:0]   x_val,
  input  logic [SAMPLE_W-1:0]   y_val,
  output logic                  bits_enable,
  output logic [4:0]            active_table,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [2*SAMPLE_W-1:0] wr_data,
  output logic                  granule_done,
  output logic                  err_overrun
);

  pair_sink_state_t    r_state;
  logic [ADDR_W-1:0]   r_pair_cnt;
  logic [ADDR_W-1:0]   r_big_values;
  logic [REGION_W-1:0] r_region1_start;
  logic [REGION_W-1:0] r_region2_start;
  table_sel_t          r_table_sel0;
  table_sel_t          r_table_sel1;
  table_sel_t          r_table_sel2;
  logic                r_err_overrun;

  logic [ADDR_W-1:0]   w_big_values_clamped;
  logic                w_pair_accept;
  logic                w_last_pair;
  logic                w_zfill_wr;

  assign w_big_values_clamped = clamp_big_values(big_values);
  assign w_pair_accept = (r_state == BIGV) && pair_valid && !start && !rst;
  assign w_zfill_wr    = (r_state == ZFILL) && !start && !rst;
  assign w_last_pair   = (r_pair_cnt == (r_big_values - ADDR_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_pair_cnt      <= '0;
      r_big_values    <= '0;
      r_region1_start <= '0;
      r_region2_start <= '0;
      r_table_sel0    <= '0;
      r_table_sel1    <= '0;
      r_table_sel2    <= '0;
      r_err_overrun   <= 1'b0;
    end else if (start) begin
      r_big_values    <= w_big_values_clamped;
      r_region1_start <= region1_start;
      r_region2_start <= region2_start;
      r_table_sel0    <= table_sel0;
      r_table_sel1    <= table_sel1;
      r_table_sel2    <= table_sel2;
      r_pair_cnt      <= '0;
      r_err_overrun   <= 1'b0;
      r_state         <= (w_big_values_clamped == '0) ? ZFILL : BIGV;
    end else begin
      if (pair_valid && (r_state != BIGV))
        r_err_overrun <= 1'b1;
      unique case (r_state)
        IDLE: ;
        BIGV: begin
          if (pair_valid) begin
            // A full granule of pairs leaves nothing to fill; hold the count at the last slot.
            if (w_last_pair && (r_big_values == ADDR_W'(GRANULE_PAIRS))) begin
              r_state <= DONE;
            end else begin
              r_pair_cnt <= r_pair_cnt + ADDR_W'(1);
              if (w_last_pair)
                r_state <= ZFILL;
            end
          end
        end
        ZFILL: begin
          if (r_pair_cnt == ADDR_W'(GRANULE_PAIRS - 1))
            r_state <= DONE;
          else
            r_pair_cnt <= r_pair_cnt + ADDR_W'(1);
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  huff_region_sel u_region_sel (
    .i_pair_cnt      (r_pair_cnt),
    .i_region1_start (r_region1_start),
    .i_region2_start (r_region2_start),
    .i_table_sel0    (r_table_sel0),
    .i_table_sel1    (r_table_sel1),
    .i_table_sel2    (r_table_sel2),
    .o_active_table  (active_table)
  );

  assign bits_enable  = (r_state == BIGV);
  assign granule_done = (r_state == DONE);
  assign err_overrun  = r_err_overrun;
  assign wr_en        = w_pair_accept || w_zfill_wr;
  assign wr_addr      = r_pair_cnt;
  assign wr_data      = w_pair_accept ? {x_val, y_val} : '0;

endmodule
